// File: rtl/lsu_mem_initiator_if.sv
// CPU request/response and MMU bus bundle for the load/store initiator.
// master = the initiator itself, slave = the CPU pipeline plus MMU environment.
interface lsu_mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_store_data;
  logic        resp_valid;
  logic [31:0] resp_load_data;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic        mem_signed_read;
  logic [1:0]  mem_data_width;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_ready;

  modport master (
    input  req_valid, req_store, req_funct3, req_base, req_offset, req_store_data,
    output req_ready, resp_valid, resp_load_data, resp_fault, resp_cause,
    output mem_write_enable, mem_read_enable, mem_signed_read, mem_data_width,
    output mem_address, mem_data_out,
    input  mem_data_in, mem_ready
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_base, req_offset, req_store_data,
    input  req_ready, resp_valid, resp_load_data, resp_fault, resp_cause,
    input  mem_write_enable, mem_read_enable, mem_signed_read, mem_data_width,
    input  mem_address, mem_data_out,
    output mem_data_in, mem_ready
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator: decodes funct3, computes the effective
// address, runs one MMU transaction and reports completion or fault.
module lsu_mem_initiator #(
  parameter bit          ALLOW_MISALIGNED = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic               clk,
  input  logic               reset,
  lsu_mem_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FAULT} state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  width_q, width_d;
  logic        signed_q, signed_d;
  logic        store_q, store_d;
  logic [1:0]  pcause_q, pcause_d;
  logic        rvalid_q, rvalid_d;
  logic        rfault_q, rfault_d;
  logic [1:0]  rcause_q, rcause_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] ea;
  logic [1:0]  dec_width;
  logic        dec_signed;
  logic        dec_illegal;
  logic        misaligned;

  assign ea = bus.req_base + bus.req_offset;

  always_comb begin
    dec_width   = 2'd0;
    dec_signed  = 1'b0;
    dec_illegal = 1'b0;
    if (bus.req_store) begin
      case (bus.req_funct3)
        3'b000:  dec_width = 2'd0;
        3'b001:  dec_width = 2'd1;
        3'b010:  dec_width = 2'd3;
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (bus.req_funct3)
        3'b000:  begin dec_width = 2'd0; dec_signed = 1'b1; end
        3'b001:  begin dec_width = 2'd1; dec_signed = 1'b1; end
        3'b010:  begin dec_width = 2'd3; dec_signed = 1'b1; end
        3'b100:  dec_width = 2'd0;
        3'b101:  dec_width = 2'd1;
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Width code doubles as "extra bytes beyond the first", so the last byte lane is offset+width.
  assign misaligned = ({1'b0, ea[1:0]} + {1'b0, dec_width}) > 3'd3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      width_q  <= '0;
      signed_q <= 1'b0;
      store_q  <= 1'b0;
      pcause_q <= '0;
      rvalid_q <= 1'b0;
      rfault_q <= 1'b0;
      rcause_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      width_q  <= width_d;
      signed_q <= signed_d;
      store_q  <= store_d;
      pcause_q <= pcause_d;
      rvalid_q <= rvalid_d;
      rfault_q <= rfault_d;
      rcause_q <= rcause_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    width_d  = width_q;
    signed_d = signed_q;
    store_d  = store_q;
    pcause_d = pcause_q;
    rvalid_d = 1'b0;
    rfault_d = rfault_q;
    rcause_d = rcause_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d   = ea;
          wdata_d  = bus.req_store_data;
          width_d  = dec_width;
          signed_d = dec_signed;
          store_d  = bus.req_store;
          if (dec_illegal) begin
            state_d  = FAULT;
            pcause_d = 2'd2;
          end else if (misaligned && !ALLOW_MISALIGNED) begin
            state_d  = FAULT;
            pcause_d = 2'd1;
          end else begin
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // MMU ready is registered on its side, so a 1 here already reflects this access.
        if (bus.mem_ready) begin
          rvalid_d = 1'b1;
          rfault_d = 1'b0;
          rcause_d = 2'd0;
          if (!store_q) rdata_d = bus.mem_data_in;
          state_d  = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rvalid_d = 1'b1;
          rfault_d = 1'b1;
          rcause_d = 2'd3;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      FAULT: begin
        rvalid_d = 1'b1;
        rfault_d = 1'b1;
        rcause_d = pcause_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready        = (state_q == IDLE);
    bus.mem_read_enable  = (state_q == ISSUE) && !store_q;
    bus.mem_write_enable = (state_q == ISSUE) && store_q;
    bus.mem_address      = addr_q;
    bus.mem_data_out     = wdata_q;
    bus.mem_data_width   = width_q;
    bus.mem_signed_read  = signed_q;
    bus.resp_valid       = rvalid_q;
    bus.resp_fault       = rfault_q;
    bus.resp_cause       = rcause_q;
    bus.resp_load_data   = rdata_q;
  end

endmodule
